// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares the single LSU data port between the core pipeline
// (requester 0) and the interrupt context save/restore engine (requester 1).
// One transfer per cycle; load data is registered back to the winning requester.
module lsu_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [2:0]  LD_IDLE    = 3'b010
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_m0_req,
    input  logic        i_m0_wren,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [2:0]  i_m0_ld_en,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_req,
    input  logic        i_m1_wren,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [2:0]  i_m1_ld_en,
    input  logic        i_m1_lock,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,

    output logic        o_lsu_wren,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [2:0]  o_ld_en,
    input  logic [31:0] i_ld_data,
    output logic        o_locked
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               gnt0;
    logic               gnt1;
    logic               starve_hit;

    assign starve_hit = (cnt_q == CNT_W'(STARVE_MAX));

    // State and starvation counter register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_ARB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: lock entry/exit and starvation counting (frozen in LOCK)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ARB: begin
                if (gnt0 || !i_m0_req) begin
                    cnt_d = '0;
                end else if (gnt1 && !starve_hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (gnt1 && i_m1_lock) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (!i_m1_lock) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Grant decision and LSU request mux; nothing granted while reset is held
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        o_lsu_wren = 1'b0;
        o_lsu_addr = '0;
        o_st_data  = '0;
        o_ld_en    = LD_IDLE;
        if (i_rst) begin
            case (state_q)
                ST_ARB: begin
                    if (i_m0_req && i_m1_req) begin
                        gnt0 = starve_hit;
                        gnt1 = !starve_hit;
                    end else begin
                        gnt0 = i_m0_req;
                        gnt1 = i_m1_req;
                    end
                end
                ST_LOCK: begin
                    gnt1 = i_m1_req;
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
        if (gnt0) begin
            o_lsu_wren = i_m0_wren;
            o_lsu_addr = i_m0_addr;
            o_st_data  = i_m0_wdata;
            o_ld_en    = i_m0_ld_en;
        end else if (gnt1) begin
            o_lsu_wren = i_m1_wren;
            o_lsu_addr = i_m1_addr;
            o_st_data  = i_m1_wdata;
            o_ld_en    = i_m1_ld_en;
        end
    end

    assign o_m0_gnt = gnt0;
    assign o_m1_gnt = gnt1;
    assign o_locked = (state_q == ST_LOCK);

    // Requester 0 load return: capture LSU data at the end of a load grant
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_m0_rvalid <= 1'b0;
            o_m0_rdata  <= '0;
        end else begin
            o_m0_rvalid <= gnt0 && !i_m0_wren;
            if (gnt0 && !i_m0_wren) begin
                o_m0_rdata <= i_ld_data;
            end
        end
    end

    // Requester 1 load return: capture LSU data at the end of a load grant
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_m1_rvalid <= 1'b0;
            o_m1_rdata  <= '0;
        end else begin
            o_m1_rvalid <= gnt1 && !i_m1_wren;
            if (gnt1 && !i_m1_wren) begin
                o_m1_rdata <= i_ld_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Directed self-checking bench for lsu_port_arbiter (STARVE_MAX=4).
module tb_lsu_port_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic        i_m0_req;
    logic        i_m0_wren;
    logic [31:0] i_m0_addr;
    logic [31:0] i_m0_wdata;
    logic [2:0]  i_m0_ld_en;
    logic        o_m0_gnt;
    logic        o_m0_rvalid;
    logic [31:0] o_m0_rdata;
    logic        i_m1_req;
    logic        i_m1_wren;
    logic [31:0] i_m1_addr;
    logic [31:0] i_m1_wdata;
    logic [2:0]  i_m1_ld_en;
    logic        i_m1_lock;
    logic        o_m1_gnt;
    logic        o_m1_rvalid;
    logic [31:0] o_m1_rdata;
    logic        o_lsu_wren;
    logic [31:0] o_lsu_addr;
    logic [31:0] o_st_data;
    logic [2:0]  o_ld_en;
    logic [31:0] i_ld_data;
    logic        o_locked;

    int n_cmp;
    int n_err;

    lsu_port_arbiter #(
        .STARVE_MAX (4),
        .LD_IDLE    (3'b010)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_m0_req    (i_m0_req),
        .i_m0_wren   (i_m0_wren),
        .i_m0_addr   (i_m0_addr),
        .i_m0_wdata  (i_m0_wdata),
        .i_m0_ld_en  (i_m0_ld_en),
        .o_m0_gnt    (o_m0_gnt),
        .o_m0_rvalid (o_m0_rvalid),
        .o_m0_rdata  (o_m0_rdata),
        .i_m1_req    (i_m1_req),
        .i_m1_wren   (i_m1_wren),
        .i_m1_addr   (i_m1_addr),
        .i_m1_wdata  (i_m1_wdata),
        .i_m1_ld_en  (i_m1_ld_en),
        .i_m1_lock   (i_m1_lock),
        .o_m1_gnt    (o_m1_gnt),
        .o_m1_rvalid (o_m1_rvalid),
        .o_m1_rdata  (o_m1_rdata),
        .o_lsu_wren  (o_lsu_wren),
        .o_lsu_addr  (o_lsu_addr),
        .o_st_data   (o_st_data),
        .o_ld_en     (o_ld_en),
        .i_ld_data   (i_ld_data),
        .o_locked    (o_locked)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_m0_req = 1'b0; i_m0_wren = 1'b0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_ld_en = 3'b010;
        i_m1_req = 1'b0; i_m1_wren = 1'b0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_ld_en = 3'b010;
        i_m1_lock = 1'b0;
        i_ld_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1'b0;
        i_m0_req = 1'b1; i_m0_wren = 1'b1; i_m0_addr = 32'h0000_7F00; i_m0_wdata = 32'h5A5A_5A5A;
        tick(); tick();
        #1;
        n_cmp++; if (o_m0_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt0 act=%0b exp=0", o_m0_gnt); end
        n_cmp++; if (o_lsu_wren !== 1'b0) begin n_err++; $display("FAIL rst_wren act=%0b exp=0", o_lsu_wren); end
        n_cmp++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL rst_locked act=%0b exp=0", o_locked); end
        n_cmp++; if (o_m0_rvalid !== 1'b0 || o_m1_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid act=%0b%0b exp=00", o_m0_rvalid, o_m1_rvalid); end
        n_cmp++; if (o_m0_rdata !== 32'h0 || o_m1_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata act=%h/%h exp=0/0", o_m0_rdata, o_m1_rdata); end
        n_cmp++; if (o_ld_en !== 3'b010) begin n_err++; $display("FAIL rst_ld_en act=%b exp=010", o_ld_en); end
        tick();
        // release with the request still present: granted on the first live cycle
        i_rst = 1'b1;
        #1;
        n_cmp++; if (o_m0_gnt !== 1'b1) begin n_err++; $display("FAIL rel_gnt0 act=%0b exp=1", o_m0_gnt); end
        n_cmp++; if (o_lsu_addr !== 32'h0000_7F00) begin n_err++; $display("FAIL rel_addr act=%h exp=00007f00", o_lsu_addr); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_single_load();
        i_m0_req = 1'b1; i_m0_wren = 1'b0; i_m0_addr = 32'h0000_2000; i_m0_ld_en = 3'b010;
        i_ld_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (o_m0_gnt !== 1'b1) begin n_err++; $display("FAIL ld_gnt0 act=%0b exp=1", o_m0_gnt); end
        n_cmp++; if (o_m1_gnt !== 1'b0) begin n_err++; $display("FAIL ld_gnt1 act=%0b exp=0", o_m1_gnt); end
        n_cmp++; if (o_lsu_addr !== 32'h0000_2000) begin n_err++; $display("FAIL ld_addr act=%h exp=00002000", o_lsu_addr); end
        n_cmp++; if (o_lsu_wren !== 1'b0) begin n_err++; $display("FAIL ld_wren act=%0b exp=0", o_lsu_wren); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (o_m0_rvalid !== 1'b1) begin n_err++; $display("FAIL ld_rvalid act=%0b exp=1", o_m0_rvalid); end
        n_cmp++; if (o_m0_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ld_rdata act=%h exp=deadbeef", o_m0_rdata); end
        n_cmp++; if (o_m1_rvalid !== 1'b0) begin n_err++; $display("FAIL ld_m1_rvalid act=%0b exp=0", o_m1_rvalid); end
        tick();
        n_cmp++; if (o_m0_rvalid !== 1'b0) begin n_err++; $display("FAIL ld_pulse act=%0b exp=0", o_m0_rvalid); end
        n_cmp++; if (o_m0_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ld_hold act=%h exp=deadbeef", o_m0_rdata); end
    endtask

    task automatic test_contention();
        logic exp1;
        i_m0_req = 1'b1; i_m0_wren = 1'b1; i_m0_addr = 32'h0000_6000; i_m0_wdata = 32'h0;
        i_m1_req = 1'b1; i_m1_wren = 1'b1; i_m1_addr = 32'h0000_6100; i_m1_wdata = 32'h1;
        for (int i = 0; i < 10; i++) begin
            exp1 = ((i % 5) != 4);
            #1;
            n_cmp++; if (o_m1_gnt !== exp1 || o_m0_gnt !== !exp1) begin
                n_err++; $display("FAIL arb_cyc%0d act=m0:%0b m1:%0b exp=m0:%0b m1:%0b", i, o_m0_gnt, o_m1_gnt, !exp1, exp1);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock_burst();
        logic [31:0] a;
        i_m0_req = 1'b1; i_m0_wren = 1'b1; i_m0_addr = 32'h0000_7100; i_m0_wdata = 32'hCAFE_0000;
        i_m1_req = 1'b1; i_m1_wren = 1'b1; i_m1_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 32'h0000_7000 + 32'(k * 4);
            i_m1_addr = a; i_m1_wdata = 32'hA0 + 32'(k);
            #1;
            n_cmp++; if (o_m1_gnt !== 1'b1 || o_m0_gnt !== 1'b0) begin n_err++; $display("FAIL lk_gnt%0d act=m0:%0b m1:%0b exp=m0:0 m1:1", k, o_m0_gnt, o_m1_gnt); end
            n_cmp++; if (o_lsu_wren !== 1'b1 || o_lsu_addr !== a || o_st_data !== 32'hA0 + 32'(k)) begin
                n_err++; $display("FAIL lk_bus%0d act=%0b/%h/%h exp=1/%h/%h", k, o_lsu_wren, o_lsu_addr, o_st_data, a, 32'hA0 + 32'(k));
            end
            n_cmp++; if (o_locked !== (k != 0)) begin n_err++; $display("FAIL lk_locked%0d act=%0b exp=%0b", k, o_locked, k != 0); end
            tick();
        end
        // lock dropped: this cycle is still LOCK, m0 blocked, LSU idle
        i_m1_req = 1'b0; i_m1_lock = 1'b0;
        #1;
        n_cmp++; if (o_locked !== 1'b1) begin n_err++; $display("FAIL lk_tail_locked act=%0b exp=1", o_locked); end
        n_cmp++; if (o_m0_gnt !== 1'b0 || o_lsu_wren !== 1'b0) begin n_err++; $display("FAIL lk_tail_idle act=gnt0:%0b wren:%0b exp=0/0", o_m0_gnt, o_lsu_wren); end
        tick();
        #1;
        n_cmp++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL lk_exit act=%0b exp=0", o_locked); end
        n_cmp++; if (o_m0_gnt !== 1'b1 || o_lsu_addr !== 32'h0000_7100) begin n_err++; $display("FAIL lk_m0_after act=%0b/%h exp=1/00007100", o_m0_gnt, o_lsu_addr); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_store();
        i_m0_req = 1'b1; i_m0_wren = 1'b1; i_m0_addr = 32'h0000_7010; i_m0_wdata = 32'h0000_00A5; i_m0_ld_en = 3'b010;
        #1;
        n_cmp++; if (o_m0_gnt !== 1'b1 || o_lsu_wren !== 1'b1) begin n_err++; $display("FAIL st_gnt act=%0b/%0b exp=1/1", o_m0_gnt, o_lsu_wren); end
        n_cmp++; if (o_lsu_addr !== 32'h0000_7010 || o_st_data !== 32'h0000_00A5) begin n_err++; $display("FAIL st_bus act=%h/%h exp=00007010/000000a5", o_lsu_addr, o_st_data); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (o_lsu_wren !== 1'b0 || o_ld_en !== 3'b010 || o_lsu_addr !== 32'h0) begin n_err++; $display("FAIL st_idle act=%0b/%b/%h exp=0/010/0", o_lsu_wren, o_ld_en, o_lsu_addr); end
        n_cmp++; if (o_m0_rvalid !== 1'b0) begin n_err++; $display("FAIL st_no_rvalid act=%0b exp=0", o_m0_rvalid); end
        tick();
    endtask

    task automatic test_isolation();
        i_m1_req = 1'b1; i_m1_wren = 1'b0; i_m1_addr = 32'h0000_2004; i_m1_ld_en = 3'b010;
        i_ld_data = 32'h1111_1111;
        #1;
        n_cmp++; if (o_m1_gnt !== 1'b1) begin n_err++; $display("FAIL iso_gnt1 act=%0b exp=1", o_m1_gnt); end
        tick();
        idle_inputs();
        i_m0_req = 1'b1; i_m0_wren = 1'b0; i_m0_addr = 32'h0000_2008; i_m0_ld_en = 3'b010;
        i_ld_data = 32'h2222_2222;
        #1;
        n_cmp++; if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL iso_m1_data act=%0b/%h exp=1/11111111", o_m1_rvalid, o_m1_rdata); end
        n_cmp++; if (o_m0_rvalid !== 1'b0 || o_m0_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL iso_m0_hold act=%0b/%h exp=0/deadbeef", o_m0_rvalid, o_m0_rdata); end
        n_cmp++; if (o_m0_gnt !== 1'b1) begin n_err++; $display("FAIL iso_gnt0 act=%0b exp=1", o_m0_gnt); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL iso_m0_data act=%0b/%h exp=1/22222222", o_m0_rvalid, o_m0_rdata); end
        n_cmp++; if (o_m1_rvalid !== 1'b0 || o_m1_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL iso_m1_hold act=%0b/%h exp=0/11111111", o_m1_rvalid, o_m1_rdata); end
        tick();
        n_cmp++; if (o_m0_rvalid !== 1'b0 || o_m1_rvalid !== 1'b0) begin n_err++; $display("FAIL iso_pulse act=%0b%0b exp=00", o_m0_rvalid, o_m1_rvalid); end
    endtask

    task automatic test_reset_mid();
        i_m0_req = 1'b1; i_m0_wren = 1'b0; i_m0_addr = 32'h0000_4000; i_m0_ld_en = 3'b010;
        i_m1_req = 1'b1; i_m1_wren = 1'b0; i_m1_addr = 32'h0000_3000; i_m1_ld_en = 3'b010; i_m1_lock = 1'b1;
        i_ld_data = 32'h3333_3333;
        #1;
        n_cmp++; if (o_m1_gnt !== 1'b1) begin n_err++; $display("FAIL rm_gnt1 act=%0b exp=1", o_m1_gnt); end
        tick();
        i_m1_addr = 32'h0000_3004;
        #1;
        n_cmp++; if (o_locked !== 1'b1 || o_m1_rvalid !== 1'b1) begin n_err++; $display("FAIL rm_pre act=%0b/%0b exp=1/1", o_locked, o_m1_rvalid); end
        i_rst = 1'b0;
        #1;
        n_cmp++; if (o_locked !== 1'b0 || o_m1_rvalid !== 1'b0) begin n_err++; $display("FAIL rm_drop act=%0b/%0b exp=0/0", o_locked, o_m1_rvalid); end
        n_cmp++; if (o_m1_gnt !== 1'b0 || o_m0_gnt !== 1'b0 || o_lsu_wren !== 1'b0) begin n_err++; $display("FAIL rm_gnt act=%0b%0b%0b exp=000", o_m0_gnt, o_m1_gnt, o_lsu_wren); end
        tick();
        i_m1_req = 1'b0; i_m1_lock = 1'b0;
        i_ld_data = 32'h4444_4444;
        i_rst = 1'b1;
        #1;
        n_cmp++; if (o_m0_gnt !== 1'b1 || o_locked !== 1'b0 || o_lsu_addr !== 32'h0000_4000) begin n_err++; $display("FAIL rm_after act=%0b/%0b/%h exp=1/0/00004000", o_m0_gnt, o_locked, o_lsu_addr); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'h4444_4444) begin n_err++; $display("FAIL rm_ld act=%0b/%h exp=1/44444444", o_m0_rvalid, o_m0_rdata); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        i_rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_load();
        test_contention();
        test_lock_burst();
        test_store();
        test_isolation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_port_arbiter.md
Name: lsu_port_arbiter

Overview:
- Shares the single LSU data port between two requesters: requester 0 is the core pipeline data port, and requester 1 is the interrupt context save/restore engine.
- Sequences one transfer per cycle into the LSU and registers read data back to the winning requester.
- Sits between the pipeline MEM stage, the interrupt controller and the LSU.

Parameters:
- STARVE_MAX, 4: maximum consecutive requester-1 grants while requester 0 waits, outside lock. Range 1..7.
- LD_IDLE, 3'b010: i_ld_en encoding driven to the LSU when idle (LW).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_m0_req  in  1  core transfer request.
- i_m0_wren  in  1  core: 1 = store, 0 = load.
- i_m0_addr  in  32  core address.
- i_m0_wdata  in  32  core store data.
- i_m0_ld_en  in  3  core size/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- o_m0_gnt  out  1  core transfer accepted this cycle.
- o_m0_rvalid  out  1  core load data valid.
- o_m0_rdata  out  32  core load data.
- i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_ld_en: same as m0, for the interrupt engine.
- i_m1_lock  in  1  interrupt engine requests exclusive ownership (burst save/restore).
- o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as m0.
- o_lsu_wren  out  1  to LSU i_lsu_wren.
- o_lsu_addr  out  32  to LSU i_lsu_addr.
- o_st_data  out  32  to LSU i_st_data.
- o_ld_en  out  3  to LSU i_ld_en.
- i_ld_data  in  32  from LSU o_ld_data (combinational read).
- o_locked  out  1  state == LOCK.

Behaviour:
- Reset (i_rst=0, async):
  - state=ARB, starve counter=0.
  - o_m0_rvalid=o_m1_rvalid=0, o_m0_rdata=o_m1_rdata=0, o_locked=0.
  - Combinational grants forced 0 and o_lsu_wren forced 0 while reset is held.
- Grants are combinational from the current requests and state. At most one grant is high per cycle.
- Granted requester's wren/addr/wdata/ld_en are muxed straight to the LSU in the same cycle.
- No grant: o_lsu_wren=0, o_lsu_addr=0, o_st_data=0, o_ld_en=LD_IDLE.
- Store completes at the rising edge ending the grant cycle (LSU write timing). No rvalid is generated for stores.
- Load: i_ld_data is sampled at the edge ending the grant cycle into the winner's rdata, and its rvalid pulses high for exactly 1 cycle after. Latency gnt->rvalid = 1 cycle.
- rdata holds its last value until the next load for that requester. The other requester's rdata/rvalid are unaffected.
- State ARB:
  - Only one requester requesting -> it is granted.
  - Both requesting, counter<STARVE_MAX -> m1 granted, counter+1.
  - Both requesting, counter==STARVE_MAX -> m0 granted, counter cleared.
  - Counter also clears whenever m0 is granted or i_m0_req=0. It saturates at STARVE_MAX.
  - m1 granted with i_m1_lock=1 -> next state LOCK (counter frozen).
- State LOCK:
  - o_m0_gnt=0 regardless of i_m0_req.
  - o_m1_gnt=i_m1_req. Starvation is not applied.
  - i_m1_lock=0 sampled at an edge -> next state ARB. The cycle in which lock is low is still a LOCK cycle (m0 blocked). Counter frozen, resumes in ARB.
  - Lock held with i_m1_req=0: LSU idle, m0 still blocked.
- i_m1_lock without i_m1_req in ARB has no effect.
- Requesters hold req/addr/data stable until gnt. The arbiter never grants a request that was dropped before its grant cycle.
- Reset asserted mid-LOCK or mid-load: immediate return to ARB. Any pending rvalid is cancelled. No write is issued while reset is low.
- Same-cycle reset release with requests present: arbitration starts on the first cycle with i_rst=1.

Test Plan:
- Single core load: reset, i_m0_req=1, wren=0, addr=0x2000, ld_en=010, LSU returns 0xDEADBEEF -> o_m0_gnt=1 that cycle, o_lsu_addr=0x2000; next cycle o_m0_rvalid=1, o_m0_rdata=0xDEADBEEF, o_m1_rvalid=0.
- Contention/starvation, STARVE_MAX=4: both requesters held continuously -> grant pattern m1,m1,m1,m1,m0, repeating; o_m0_gnt never high two cycles in a row.
- Lock burst: m1 stores to 0x7000..0x700C with lock=1, m0 requesting throughout -> 4 consecutive m1 grants and o_locked=1. Lock dropped after 4th -> m0 granted on the first ARB cycle; LSU sees wren=1 with correct addr/data each locked cycle.
- Store path: m0 store wren=1, addr=0x7010, wdata=0x0000_00A5, ld_en=010 -> o_lsu_wren=1 for exactly 1 cycle, no rvalid; idle afterwards gives o_lsu_wren=0, o_ld_en=010.
- Reset mid-operation: assert i_rst=0 during LOCK with a load granted the previous cycle -> o_locked, rvalid and gnt drop to 0 immediately; after release m0 alone is granted in the first cycle.
- Isolation: interleaved loads m1@0x2004 (0x11111111) then m0@0x2008 (0x22222222) -> o_m1_rdata=0x11111111 persists while o_m0_rdata updates to 0x22222222; each rvalid pulses once.
